elevator_ctrl: RTL and testbench
================================

Name: elevator_ctrl

Overview:
Car-motion controller that sits directly upstream of the Display block. It latches hall/car floor requests, runs a SCAN (keep-direction) scheduler over the floors, and times moves and door dwell from a 1 Hz enable. Its floor, countdown, status and floor_btn outputs connect straight to the Display inputs of the same names.

Parameters:
NUM_FLOORS, 8, number of served floors (2..8); floors are 0..NUM_FLOORS-1.
MOVE_TIME, 3, ticks to travel one floor (1..9; the display shows one digit).
DOOR_TIME, 5, ticks the door stays open (1..9).

Ports:
ck  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset.
tick  input  1  one-ck-wide 1 Hz enable; timing advances only on ck edges where tick=1.
req_btn  input  8  request pulses, one bit per floor; several bits may be high at once.
floor  output  4  current floor number.
countdown  output  4  ticks remaining in the current move or door phase; 0 when idle.
status  output  4  one-hot state: 0001 IDLE, 0010 UP, 0100 DOWN, 1000 DOOR.
floor_btn  output  8  latched pending requests, bit i = floor i.

Behaviour:
- Reset (rst_n=0 at a ck edge): floor=0, countdown=0, status=IDLE, floor_btn=0, internal dir=up. This applies from any state, including mid-move or with the door open.
- Request latch, every cycle: floor_btn <= (floor_btn | req_btn_masked) & ~clear.
  - req_btn_masked zeroes bits >= NUM_FLOORS.
  - req_btn_masked also zeroes the current-floor bit while in IDLE or DOOR. In IDLE that press opens the door; in DOOR it restarts the dwell.
  - clear is the one-hot bit of the floor being served this edge. If a press and a clear hit the same bit on the same edge, clear wins.
- "above" means any floor_btn bit > floor. "below" means any floor_btn bit < floor.
- IDLE (countdown=0). Decides on every ck edge; tick is not required:
  - Current-floor req_btn bit set: go to DOOR, countdown=DOOR_TIME.
  - Else if above and (dir=up or not below): go to UP, dir=up, countdown=MOVE_TIME.
  - Else if below: go to DOWN, dir=down, countdown=MOVE_TIME.
  - Else stay in IDLE.
  - Requests latched in an earlier cycle are evaluated on the next edge, so the latency from press to leaving IDLE is 1 ck for a same-floor press and 2 ck for any other floor.
- UP / DOWN, on tick:
  - If countdown>1: countdown-1.
  - If countdown=1: floor<=floor±1 (nf = new floor). Then:
    - floor_btn[nf] set: go to DOOR, countdown=DOOR_TIME, clear bit nf.
    - Else requests remain beyond nf in the same direction: stay in the state, countdown=MOVE_TIME.
    - Else: go to IDLE, countdown=0.
  - floor never exceeds NUM_FLOORS-1 and never goes below 0. UP is never entered at the top floor, nor DOWN at floor 0.
- DOOR, on tick:
  - If countdown>1: countdown-1.
  - If countdown=1: go to IDLE, countdown=0.
  - A current-floor press, on any edge, reloads countdown to DOOR_TIME. On an edge where both a tick and that press occur, the reload wins.
- status changes on the same edge as the state. floor and countdown are registered; there is no combinational path from inputs to outputs.
- Arithmetic: 4-bit unsigned. countdown never underflows because the decrement happens only when countdown>1.

Test Plan:
1. Reset, then idle: hold rst_n=0 for 2 ck, release -> floor=0, status=0001, countdown=0, floor_btn=0 and they remain so with tick toggling.
2. Single trip up: pulse req_btn=8'h08 at floor 0 ->
   - floor_btn=08; status=0010 with countdown=3.
   - floor increments every 3 ticks through 1 and 2.
   - On arrival at 3: status=1000, countdown=5, floor_btn=00.
   - After 5 more ticks: status=0001, countdown=0.
3. Door hold: during DOOR at floor 3 with countdown=2, pulse req_btn=8'h08 -> countdown=5, floor_btn stays 00.
4. SCAN order: at floor 2 moving UP, press floors 5 and 0 ->
   - Car stops at 5 (door), then reverses.
   - status=0100, stops at 0.
   - floor_btn bits clear in order 20 then 01.
5. Same-floor press while moving: car leaving floor 2 UP toward 4, press 8'h04 -> bit 2 latched; car serves 4, returns DOWN to 2.
6. Reset mid-move: assert rst_n=0 while status=0100 at floor 5 with floor_btn=01 -> next edge: floor=0, status=0001, countdown=0, floor_btn=00.

Source files
------------

// File: rtl/elevator_ctrl.sv
// elevator_ctrl -- car-motion controller feeding the Display block.
//
// Latches floor requests, runs a SCAN (keep-direction) scheduler and times
// floor-to-floor moves and door dwell from a one-cycle 1 Hz enable.
//
// Ports:
//   ck         system clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   tick       one-ck-wide 1 Hz enable for move/door timing
//   req_btn    request pulses, one bit per floor
//   floor      current floor number
//   countdown  ticks left in the current move or door phase (0 when idle)
//   status     one-hot state: 0001 IDLE, 0010 UP, 0100 DOWN, 1000 DOOR
//   floor_btn  latched pending requests, bit i = floor i
module elevator_ctrl #(
   parameter int NUM_FLOORS = 8,
   parameter int MOVE_TIME  = 3,
   parameter int DOOR_TIME  = 5
) (
   input  logic       ck,
   input  logic       rst_n,
   input  logic       tick,
   input  logic [7:0] req_btn,
   output logic [3:0] floor,
   output logic [3:0] countdown,
   output logic [3:0] status,
   output logic [7:0] floor_btn
);

   typedef enum logic [3:0] {
      IDLE = 4'b0001,
      UP   = 4'b0010,
      DOWN = 4'b0100,
      DOOR = 4'b1000
   } state_t;

   localparam logic [3:0] MOVE_T = 4'(MOVE_TIME);
   localparam logic [3:0] DOOR_T = 4'(DOOR_TIME);

   state_t     state_reg, state_next;
   logic [3:0] floor_reg, floor_next;
   logic [3:0] count_reg, count_next;
   logic       dir_up_reg, dir_up_next;
   logic [7:0] btn_reg, btn_next;

   logic [7:0] valid_mask;
   logic [7:0] above_bits, below_bits;
   logic [7:0] past_up_bits, past_down_bits;
   logic [7:0] req_masked, clear;
   logic [3:0] nf;
   logic       here, above, below, beyond;

   // Floor the car reaches when the current move completes.
   assign nf = (state_reg == DOWN) ? floor_reg - 4'd1 : floor_reg + 4'd1;

   // Per-floor position tests against the current floor and the next floor.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_bits
         assign valid_mask[gi]     = (gi < NUM_FLOORS);
         assign above_bits[gi]     = btn_reg[gi] && (4'(gi) > floor_reg);
         assign below_bits[gi]     = btn_reg[gi] && (4'(gi) < floor_reg);
         assign past_up_bits[gi]   = btn_reg[gi] && (4'(gi) > nf);
         assign past_down_bits[gi] = btn_reg[gi] && (4'(gi) < nf);
      end
   endgenerate

   assign here   = req_btn[floor_reg[2:0]];
   assign above  = |above_bits;
   assign below  = |below_bits;
   assign beyond = (state_reg == UP) ? |past_up_bits : |past_down_bits;

   always_comb begin
      state_next  = state_reg;
      floor_next  = floor_reg;
      count_next  = count_reg;
      dir_up_next = dir_up_reg;
      clear       = '0;
      req_masked  = req_btn & valid_mask;

      // A press at the floor where the car stands with the door available
      // is served immediately rather than latched.
      if (state_reg == IDLE || state_reg == DOOR)
         req_masked[floor_reg[2:0]] = 1'b0;

      case (state_reg)
         IDLE: begin
            if (here) begin
               state_next               = DOOR;
               count_next               = DOOR_T;
               clear[floor_reg[2:0]]    = 1'b1;
            end else if (above && (dir_up_reg || !below)) begin
               state_next  = UP;
               dir_up_next = 1'b1;
               count_next  = MOVE_T;
            end else if (below) begin
               state_next  = DOWN;
               dir_up_next = 1'b0;
               count_next  = MOVE_T;
            end
         end
         UP, DOWN: begin
            if (tick) begin
               if (count_reg > 4'd1) begin
                  count_next = count_reg - 4'd1;
               end else begin
                  floor_next = nf;
                  if (btn_reg[nf[2:0]]) begin
                     state_next       = DOOR;
                     count_next       = DOOR_T;
                     clear[nf[2:0]]   = 1'b1;
                  end else if (beyond) begin
                     count_next = MOVE_T;
                  end else begin
                     state_next = IDLE;
                     count_next = 4'd0;
                  end
               end
            end
         end
         DOOR: begin
            // A fresh press at this floor beats a simultaneous tick.
            if (here) begin
               count_next            = DOOR_T;
               clear[floor_reg[2:0]] = 1'b1;
            end else if (tick) begin
               if (count_reg > 4'd1) begin
                  count_next = count_reg - 4'd1;
               end else begin
                  state_next = IDLE;
                  count_next = 4'd0;
               end
            end
         end
         default: begin
            state_next = IDLE;
            count_next = 4'd0;
         end
      endcase

      btn_next = (btn_reg | req_masked) & ~clear;
   end

   always_ff @(posedge ck) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         floor_reg  <= 4'd0;
         count_reg  <= 4'd0;
         dir_up_reg <= 1'b1;
         btn_reg    <= 8'h00;
      end else begin
         state_reg  <= state_next;
         floor_reg  <= floor_next;
         count_reg  <= count_next;
         dir_up_reg <= dir_up_next;
         btn_reg    <= btn_next;
      end
   end

   assign floor     = floor_reg;
   assign countdown = count_reg;
   assign status    = state_reg;
   assign floor_btn = btn_reg;

endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl -- self-checking bench for elevator_ctrl.
//
// Two instances share stimulus: the default 8-floor car (A) and a 5-floor
// car with short timings (B) that exercises request masking and the top
// floor boundary. A hand-computed vector table and directed sequences check
// A against constants; a behavioural model checks both cars every cycle.
module tb_elevator_ctrl;

   logic       ck;
   logic       rst_n;
   logic       tick;
   logic [7:0] req_btn;

   logic [3:0] floor_a, cd_a, st_a;
   logic [7:0] btn_a;
   logic [3:0] floor_b, cd_b, st_b;
   logic [7:0] btn_b;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   elevator_ctrl dut_a (
      .ck(ck), .rst_n(rst_n), .tick(tick), .req_btn(req_btn),
      .floor(floor_a), .countdown(cd_a), .status(st_a), .floor_btn(btn_a)
   );

   elevator_ctrl #(.NUM_FLOORS(5), .MOVE_TIME(1), .DOOR_TIME(2)) dut_b (
      .ck(ck), .rst_n(rst_n), .tick(tick), .req_btn(req_btn),
      .floor(floor_b), .countdown(cd_b), .status(st_b), .floor_btn(btn_b)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   // ---------------- behavioural reference model ----------------
   localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DOOR = 3;

   typedef struct {
      int       floor;
      int       count;
      int       mode;
      bit       dir_up;
      bit [7:0] pending;
   } model_t;

   model_t ma, mb;

   function automatic model_t mstep(model_t m, int nfl, int mt, int dt,
                                    bit r, bit t, logic [7:0] q);
      model_t   n;
      bit [7:0] add, clr;
      bit       here, any_above, any_below, more;
      int       nf;
      n = m;
      if (!r) begin
         n.floor = 0; n.count = 0; n.mode = M_IDLE; n.dir_up = 1'b1; n.pending = '0;
         return n;
      end
      add = '0; clr = '0;
      for (int f = 0; f < nfl; f++) add[f] = q[f];
      here = q[m.floor];
      if (m.mode == M_IDLE || m.mode == M_DOOR) add[m.floor] = 1'b0;
      any_above = 0; any_below = 0;
      for (int f = 0; f < 8; f++) begin
         if (m.pending[f] && f > m.floor) any_above = 1;
         if (m.pending[f] && f < m.floor) any_below = 1;
      end
      case (m.mode)
         M_IDLE: begin
            if (here) begin
               n.mode = M_DOOR; n.count = dt; clr[m.floor] = 1;
            end else if (any_above && (m.dir_up || !any_below)) begin
               n.mode = M_UP; n.dir_up = 1; n.count = mt;
            end else if (any_below) begin
               n.mode = M_DOWN; n.dir_up = 0; n.count = mt;
            end
         end
         M_UP, M_DOWN: if (t) begin
            if (m.count > 1) n.count = m.count - 1;
            else begin
               nf = (m.mode == M_UP) ? m.floor + 1 : m.floor - 1;
               n.floor = nf;
               more = 0;
               for (int f = 0; f < 8; f++)
                  if (m.pending[f] && ((m.mode == M_UP) ? (f > nf) : (f < nf))) more = 1;
               if (m.pending[nf]) begin
                  n.mode = M_DOOR; n.count = dt; clr[nf] = 1;
               end else if (more) n.count = mt;
               else begin
                  n.mode = M_IDLE; n.count = 0;
               end
            end
         end
         default: begin
            if (here) begin
               n.count = dt; clr[m.floor] = 1;
            end else if (t) begin
               if (m.count > 1) n.count = m.count - 1;
               else begin
                  n.mode = M_IDLE; n.count = 0;
               end
            end
         end
      endcase
      n.pending = (m.pending | add) & ~clr;
      return n;
   endfunction

   // ---------------- comparison helpers ----------------
   task automatic cmp(input string name,
                      input logic [3:0] f, input logic [3:0] c, input logic [3:0] s, input logic [7:0] b,
                      input logic [3:0] ef, input logic [3:0] ec, input logic [3:0] es, input logic [7:0] eb);
      n_vec++;
      if ({f, c, s, b} !== {ef, ec, es, eb}) begin
         n_bad++;
         $display("FAIL %s: got floor=%0d cd=%0d status=%b btn=%h, want floor=%0d cd=%0d status=%b btn=%h",
                  name, f, c, s, b, ef, ec, es, eb);
      end
   endtask

   // One clock: apply inputs, advance models, compare both cars to them.
   task automatic cycle(input bit r, input bit t, input logic [7:0] q);
      rst_n = r; tick = t; req_btn = q;
      @(posedge ck);
      #1;
      cyc++;
      ma = mstep(ma, 8, 3, 5, r, t, q);
      mb = mstep(mb, 5, 1, 2, r, t, q);
      cmp($sformatf("modelA@%0d", cyc), floor_a, cd_a, st_a, btn_a,
          4'(ma.floor), 4'(ma.count), 4'(1 << ma.mode), ma.pending);
      cmp($sformatf("modelB@%0d", cyc), floor_b, cd_b, st_b, btn_b,
          4'(mb.floor), 4'(mb.count), 4'(1 << mb.mode), mb.pending);
      tick = 1'b0; req_btn = 8'h00;
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 8'h00);
   endtask

   task automatic expect_a(input string name, input logic [3:0] f, input logic [3:0] c,
                           input logic [3:0] s, input logic [7:0] b);
      cmp(name, floor_a, cd_a, st_a, btn_a, f, c, s, b);
      $display("%s: floor=%0d cd=%0d status=%b btn=%h", name, floor_a, cd_a, st_a, btn_a);
   endtask

   // ---------------- hand-computed vector table (car A) ----------------
   typedef struct {
      bit         r;
      bit         t;
      logic [7:0] q;
      logic [3:0] f;
      logic [3:0] c;
      logic [3:0] s;
      logic [7:0] b;
   } vec_t;

   vec_t vecs[29];

   initial begin
      rst_n = 1'b0; tick = 1'b0; req_btn = 8'h00;

      // reset held 2 ck, then idle with tick toggling
      vecs[0]  = '{1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 4'b0001, 8'h00};
      vecs[1]  = '{1'b0, 1'b1, 8'h00, 4'd0, 4'd0, 4'b0001, 8'h00};
      vecs[2]  = '{1'b1, 1'b1, 8'h00, 4'd0, 4'd0, 4'b0001, 8'h00};
      vecs[3]  = '{1'b1, 1'b0, 8'h00, 4'd0, 4'd0, 4'b0001, 8'h00};
      // single trip up to floor 3
      vecs[4]  = '{1'b1, 1'b0, 8'h08, 4'd0, 4'd0, 4'b0001, 8'h08};
      vecs[5]  = '{1'b1, 1'b0, 8'h00, 4'd0, 4'd3, 4'b0010, 8'h08};
      vecs[6]  = '{1'b1, 1'b1, 8'h00, 4'd0, 4'd2, 4'b0010, 8'h08};
      vecs[7]  = '{1'b1, 1'b0, 8'h00, 4'd0, 4'd2, 4'b0010, 8'h08};
      vecs[8]  = '{1'b1, 1'b1, 8'h00, 4'd0, 4'd1, 4'b0010, 8'h08};
      vecs[9]  = '{1'b1, 1'b1, 8'h00, 4'd1, 4'd3, 4'b0010, 8'h08};
      vecs[10] = '{1'b1, 1'b1, 8'h00, 4'd1, 4'd2, 4'b0010, 8'h08};
      vecs[11] = '{1'b1, 1'b1, 8'h00, 4'd1, 4'd1, 4'b0010, 8'h08};
      vecs[12] = '{1'b1, 1'b1, 8'h00, 4'd2, 4'd3, 4'b0010, 8'h08};
      vecs[13] = '{1'b1, 1'b1, 8'h00, 4'd2, 4'd2, 4'b0010, 8'h08};
      vecs[14] = '{1'b1, 1'b1, 8'h00, 4'd2, 4'd1, 4'b0010, 8'h08};
      vecs[15] = '{1'b1, 1'b1, 8'h00, 4'd3, 4'd5, 4'b1000, 8'h00};
      vecs[16] = '{1'b1, 1'b1, 8'h00, 4'd3, 4'd4, 4'b1000, 8'h00};
      vecs[17] = '{1'b1, 1'b1, 8'h00, 4'd3, 4'd3, 4'b1000, 8'h00};
      vecs[18] = '{1'b1, 1'b1, 8'h00, 4'd3, 4'd2, 4'b1000, 8'h00};
      // door hold: same-floor press reloads, and beats a simultaneous tick
      vecs[19] = '{1'b1, 1'b0, 8'h08, 4'd3, 4'd5, 4'b1000, 8'h00};
      vecs[20] = '{1'b1, 1'b1, 8'h08, 4'd3, 4'd5, 4'b1000, 8'h00};
      vecs[21] = '{1'b1, 1'b1, 8'h00, 4'd3, 4'd4, 4'b1000, 8'h00};
      vecs[22] = '{1'b1, 1'b1, 8'h00, 4'd3, 4'd3, 4'b1000, 8'h00};
      vecs[23] = '{1'b1, 1'b1, 8'h00, 4'd3, 4'd2, 4'b1000, 8'h00};
      vecs[24] = '{1'b1, 1'b1, 8'h00, 4'd3, 4'd1, 4'b1000, 8'h00};
      vecs[25] = '{1'b1, 1'b1, 8'h00, 4'd3, 4'd0, 4'b0001, 8'h00};
      // same-floor press in IDLE opens the door after one ck
      vecs[26] = '{1'b1, 1'b1, 8'h08, 4'd3, 4'd5, 4'b1000, 8'h00};
      vecs[27] = '{1'b1, 1'b0, 8'h00, 4'd3, 4'd5, 4'b1000, 8'h00};
      // reset with the door open
      vecs[28] = '{1'b0, 1'b1, 8'h00, 4'd0, 4'd0, 4'b0001, 8'h00};

      for (int i = 0; i < 29; i++) begin
         cycle(vecs[i].r, vecs[i].t, vecs[i].q);
         expect_a($sformatf("vec%0d", i), vecs[i].f, vecs[i].c, vecs[i].s, vecs[i].b);
      end

      // SCAN order: floor 2 going up, requests at 5 and 0
      cycle(1'b1, 1'b0, 8'h20);
      cycle(1'b1, 1'b0, 8'h00);
      run_ticks(6);
      expect_a("t4_at2", 4'd2, 4'd3, 4'b0010, 8'h20);
      cycle(1'b1, 1'b0, 8'h01);
      expect_a("t4_press0", 4'd2, 4'd3, 4'b0010, 8'h21);
      run_ticks(9);
      expect_a("t4_stop5", 4'd5, 4'd5, 4'b1000, 8'h01);
      run_ticks(5);
      expect_a("t4_idle5", 4'd5, 4'd0, 4'b0001, 8'h01);
      cycle(1'b1, 1'b0, 8'h00);
      expect_a("t4_down", 4'd5, 4'd3, 4'b0100, 8'h01);
      run_ticks(15);
      expect_a("t4_stop0", 4'd0, 4'd5, 4'b1000, 8'h00);
      run_ticks(5);

      // same-floor press while moving is latched and served on the way back
      cycle(1'b1, 1'b0, 8'h10);
      cycle(1'b1, 1'b0, 8'h00);
      run_ticks(6);
      cycle(1'b1, 1'b0, 8'h04);
      expect_a("t5_latch2", 4'd2, 4'd3, 4'b0010, 8'h14);
      run_ticks(6);
      expect_a("t5_stop4", 4'd4, 4'd5, 4'b1000, 8'h04);
      run_ticks(5);
      cycle(1'b1, 1'b0, 8'h00);
      expect_a("t5_down", 4'd4, 4'd3, 4'b0100, 8'h04);
      run_ticks(6);
      expect_a("t5_stop2", 4'd2, 4'd5, 4'b1000, 8'h00);
      run_ticks(5);

      // reset in the middle of a downward move
      cycle(1'b1, 1'b0, 8'h20);
      cycle(1'b1, 1'b0, 8'h00);
      run_ticks(9);
      run_ticks(5);
      cycle(1'b1, 1'b0, 8'h01);
      cycle(1'b1, 1'b0, 8'h00);
      run_ticks(1);
      expect_a("t6_moving", 4'd5, 4'd2, 4'b0100, 8'h01);
      cycle(1'b0, 1'b1, 8'h00);
      expect_a("t6_reset", 4'd0, 4'd0, 4'b0001, 8'h00);
      cycle(1'b1, 1'b1, 8'h00);
      expect_a("t6_after", 4'd0, 4'd0, 4'b0001, 8'h00);

      // randomized traffic, both cars checked against the model every cycle
      for (int i = 0; i < 4000; i++) begin
         bit         r, t;
         logic [7:0] q;
         r = ($urandom_range(0, 299) != 0);
         t = ($urandom_range(0, 2) == 0);
         q = ($urandom_range(0, 5) == 0) ? 8'($urandom) & 8'($urandom) : 8'h00;
         cycle(r, t, q);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
